// File: rtl/led_count_ctrl_if.sv
// Button and LED bundle between the board pins and the run-control block.
// Latency: none, wires only.
// Backpressure: none; buttons are raw levels and outputs are always-valid state.
interface led_count_ctrl_if #(
    parameter int LED_W = 6
);
    logic             btn_run_n;
    logic             btn_spd_n;
    logic             btn_clr_n;
    logic [LED_W-1:0] count_o;
    logic [1:0]       state_o;
    logic [1:0]       speed_o;

    // Board side: drives the buttons, watches the LEDs and status.
    modport master (
        output btn_run_n,
        output btn_spd_n,
        output btn_clr_n,
        input  count_o,
        input  state_o,
        input  speed_o
    );

    // Controller side.
    modport slave (
        input  btn_run_n,
        input  btn_spd_n,
        input  btn_clr_n,
        output count_o,
        output state_o,
        output speed_o
    );
endinterface

// File: rtl/led_count_ctrl.sv
// Debounced run/speed/clear buttons sequencing a rate-selectable LED step counter.
// Latency: clean button low reaches the outputs DEB_CYCLES+3 edges later; RUN steps every TICK_DIV>>speed cycles.
// Backpressure: none; every press event is consumed in the cycle it is generated.
module led_count_ctrl #(
    parameter int TICK_DIV   = 13500000,
    parameter int DEB_CYCLES = 270000,
    parameter int LED_W      = 6
) (
    input logic             clk,
    input logic             rst,
    led_count_ctrl_if.slave bus
);

    localparam int NB = 3;                    // bit 0 run, bit 1 speed, bit 2 clear
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] deb_lvl;
    logic [NB-1:0] press;
    logic [DW-1:0] deb_cnt [NB];

    state_t           state;
    logic [1:0]       speed;
    logic [LED_W-1:0] counter;
    logic [PW-1:0]    presc;
    logic [PW-1:0]    p_last;

    assign btn_raw = {bus.btn_clr_n, bus.btn_spd_n, bus.btn_run_n};

    // Two-flop synchronizers for the asynchronous button pins; idle level is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce each button and emit a one-cycle press when the clean level falls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            deb_lvl <= '1;
            press   <= '0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            press <= '0;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_lvl[i] <= sync2[i];
                    deb_cnt[i] <= '0;
                    press[i]   <= deb_lvl[i] & ~sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Last prescaler value of one step period at the current speed (period halves per speed index).
    always_comb begin
        p_last = PW'((TICK_DIV >> speed) - 1);
    end

    // Run-control FSM: clear beats speed, speed restarts the period, run toggles the mode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            speed   <= '0;
            counter <= '0;
            presc   <= '0;
        end else if (press[2]) begin
            state   <= S_IDLE;
            counter <= '0;
            presc   <= '0;
        end else begin
            if (press[0]) begin
                case (state)
                    S_IDLE:  state <= S_RUN;
                    S_RUN:   state <= S_PAUSE;
                    S_PAUSE: state <= S_RUN;
                    default: state <= S_IDLE;
                endcase
            end
            if (press[1]) begin
                speed <= speed + 2'd1;
                presc <= '0;
            end else if (state == S_RUN) begin
                if (presc == p_last) begin
                    presc   <= '0;
                    counter <= counter + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign bus.count_o = ~counter;
    assign bus.state_o = state;
    assign bus.speed_o = speed;

endmodule

// File: tb/tb_led_count_ctrl.sv
// Bench for led_count_ctrl: randomized button stimulus, abstract reference model, output-change scoreboard.
// Latency: expected changes are tagged with the exact clock edge they must appear on.
// Backpressure: none; the monitor samples every falling edge.
module tb_led_count_ctrl;

    localparam int TICK_DIV = 16;
    localparam int DEB      = 4;
    localparam int LED_W    = 6;
    localparam int LAT      = DEB + 3;

    typedef struct {
        int               e;
        logic [1:0]       st;
        logic [1:0]       sp;
        logic [LED_W-1:0] led;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    led_count_ctrl_if #(.LED_W(LED_W)) bus ();

    led_count_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .DEB_CYCLES(DEB),
        .LED_W     (LED_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    bit   ev_run[int];
    bit   ev_spd[int];
    bit   ev_clr[int];

    // reference model: mode 0 idle, 1 run, 2 pause
    int   m_mode = 0;
    int   m_spd  = 0;
    int   m_cnt  = 0;
    int   m_elapsed = 0;
    exp_t m_prev;

    logic [1:0]       o_st;
    logic [1:0]       o_sp;
    logic [LED_W-1:0] o_led;

    task automatic model_step();
        int   e;
        bit   was_run;
        exp_t now;
        e   = cyc + 1;
        cyc = e;
        if (!rst) begin
            m_mode = 0; m_spd = 0; m_cnt = 0; m_elapsed = 0;
        end else if (ev_clr.exists(e)) begin
            m_mode = 0; m_cnt = 0; m_elapsed = 0;
        end else begin
            was_run = (m_mode == 1);
            if (ev_spd.exists(e)) begin
                m_spd     = (m_spd + 1) % 4;
                m_elapsed = 0;
            end else if (was_run) begin
                m_elapsed++;
                if (m_elapsed == (TICK_DIV >> m_spd)) begin
                    m_cnt     = (m_cnt + 1) % (1 << LED_W);
                    m_elapsed = 0;
                end
            end
            if (ev_run.exists(e)) m_mode = (m_mode == 1) ? 2 : 1;
        end
        now.e   = e;
        now.st  = 2'(m_mode);
        now.sp  = 2'(m_spd);
        now.led = ~LED_W'(m_cnt);
        if (mon_en && (now.st != m_prev.st || now.sp != m_prev.sp || now.led != m_prev.led))
            sb_q.push_back(now);
        m_prev = now;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic monitor_step();
        exp_t             ex;
        logic [1:0]       st;
        logic [1:0]       sp;
        logic [LED_W-1:0] led;
        st  = bus.state_o;
        sp  = bus.speed_o;
        led = bus.count_o;
        if (st !== o_st || sp !== o_sp || led !== o_led) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_change edge=%0d got st=%b sp=%b led=%b, required no change",
                         cyc, st, sp, led);
            end else begin
                ex = sb_q.pop_front();
                if (ex.e == cyc && ex.st === st && ex.sp === sp && ex.led === led)
                    passes++;
                else
                    $display("FAIL output_change edge=%0d got st=%b sp=%b led=%b, required edge=%0d st=%b sp=%b led=%b",
                             cyc, st, sp, led, ex.e, ex.st, ex.sp, ex.led);
            end
            o_st  = st;
            o_sp  = sp;
            o_led = led;
        end
        while (sb_q.size() > 0 && sb_q[0].e < cyc) begin
            checks++;
            ex = sb_q.pop_front();
            $display("FAIL missing_change edge=%0d got st=%b sp=%b led=%b, required st=%b sp=%b led=%b at edge %0d",
                     cyc, st, sp, led, ex.st, ex.sp, ex.led, ex.e);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en) monitor_step();
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s got=%0h required=%0h", name, got, want);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press of any combination of buttons, all falling on the same cycle.
    task automatic press(bit r, bit s, bit c, int hold);
        @(negedge clk);
        if (r) begin bus.btn_run_n = 1'b0; ev_run[cyc + LAT] = 1'b1; end
        if (s) begin bus.btn_spd_n = 1'b0; ev_spd[cyc + LAT] = 1'b1; end
        if (c) begin bus.btn_clr_n = 1'b0; ev_clr[cyc + LAT] = 1'b1; end
        repeat (hold) @(negedge clk);
        bus.btn_run_n = 1'b1;
        bus.btn_spd_n = 1'b1;
        bus.btn_clr_n = 1'b1;
        repeat (DEB + 2) @(negedge clk);
    endtask

    // Contact bounce shorter than the debounce window: must register nothing.
    task automatic bounce(int which, int cycles);
        logic lvl;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            lvl = ((k / 2) % 2) != 0;
            case (which)
                0:       bus.btn_run_n = lvl;
                1:       bus.btn_spd_n = lvl;
                default: bus.btn_clr_n = lvl;
            endcase
        end
        @(negedge clk);
        bus.btn_run_n = 1'b1;
        bus.btn_spd_n = 1'b1;
        bus.btn_clr_n = 1'b1;
        repeat (DEB + 2) @(negedge clk);
    endtask

    initial begin
        int act;
        bus.btn_run_n = 1'b1;
        bus.btn_spd_n = 1'b1;
        bus.btn_clr_n = 1'b1;
        rst = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_count_o", 32'(bus.count_o), 32'h3F);
        check("reset_state_o", 32'(bus.state_o), 32'h0);
        check("reset_speed_o", 32'(bus.speed_o), 32'h0);
        o_st  = 2'b00;
        o_sp  = 2'b00;
        o_led = '1;
        mon_en = 1'b1;
        rst = 1'b1;
        idle(200);

        // bounce on run while idle
        bounce(0, 30);
        idle(30);

        // start and full wrap at speed 0
        press(1'b1, 1'b0, 1'b0, 20);
        idle(64 * TICK_DIV + 40);

        // speed cycling 1,2,3,0
        for (int i = 0; i < 4; i++) begin
            press(1'b0, 1'b1, 1'b0, 6 + i);
            idle(50 + int'($urandom_range(0, 30)));
        end

        // pause / resume
        press(1'b1, 1'b0, 1'b0, 8);
        idle(100);
        press(1'b1, 1'b0, 1'b0, 8);
        idle(60);

        // clear and run together while running
        press(1'b1, 1'b0, 1'b1, 10);
        idle(30);

        // randomized mix of presses, collisions and bounce
        for (int i = 0; i < 30; i++) begin
            act = int'($urandom_range(0, 6));
            case (act)
                0: press(1'b1, 1'b0, 1'b0, int'($urandom_range(DEB + 1, 30)));
                1: press(1'b0, 1'b1, 1'b0, int'($urandom_range(DEB + 1, 30)));
                2: press(1'b0, 1'b0, 1'b1, int'($urandom_range(DEB + 1, 30)));
                3: press(1'b1, 1'b0, 1'b1, int'($urandom_range(DEB + 1, 30)));
                4: bounce(int'($urandom_range(0, 2)), int'($urandom_range(4, 30)));
                5: press(1'b1, 1'b1, 1'b0, int'($urandom_range(DEB + 1, 30)));
                default: idle(int'($urandom_range(20, 300)));
            endcase
            idle(int'($urandom_range(0, 80)));
        end

        // reset dropped while running
        press(1'b0, 1'b0, 1'b1, 6);
        press(1'b1, 1'b0, 1'b0, 6);
        idle(40);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(50);

        // every expected change must have been seen
        checks++;
        if (sb_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain got=%0d pending required=0", sb_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
